// File: rtl/generador_pulso_sostenido.sv
// Regenerates single-cycle triggers as held pulses: HIGH_CYCLES high, then at least
// LOW_CYCLES low, with a saturating queue of triggers that arrive mid-pulse.
module generador_pulso_sostenido #(
  parameter int HIGH_CYCLES = 4,
  parameter int LOW_CYCLES  = 4,
  parameter int PEND_W      = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disparo,
  output logic              salida,
  output logic              ocupado,
  output logic [PEND_W-1:0] pendientes,
  output logic              desborde
);
  localparam int MAX_PHASE = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int CNT_W     = $clog2(MAX_PHASE + 1);
  localparam logic [CNT_W-1:0]  HIGH_LAST = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LOW_LAST  = CNT_W'(LOW_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t            state, stateNxt;
  logic [CNT_W-1:0]  cnt, cntNxt;
  logic [PEND_W-1:0] pendNxt;
  logic              ovfNxt;
  logic              lastHigh, lastLow, hayPend, start;

  assign lastHigh = (state == HIGH) && (cnt == HIGH_LAST);
  assign lastLow  = (state == LOW)  && (cnt == LOW_LAST);
  assign hayPend  = (pendientes != '0);
  // A new pulse may only begin from IDLE or on the final LOW cycle (no IDLE bubble).
  assign start    = ((state == IDLE) || lastLow) && (disparo || hayPend);

  always_comb begin
    stateNxt = state;
    cntNxt   = cnt + 1'b1;
    pendNxt  = pendientes;
    ovfNxt   = 1'b0;

    unique case (state)
      IDLE: begin
        cntNxt = '0;
        if (start) stateNxt = HIGH;
      end
      HIGH: begin
        if (lastHigh) begin
          stateNxt = LOW;
          cntNxt   = '0;
        end
      end
      LOW: begin
        if (lastLow) begin
          cntNxt   = '0;
          stateNxt = start ? HIGH : IDLE;
        end
      end
      default: begin
        stateNxt = IDLE;
        cntNxt   = '0;
      end
    endcase

    // On a start cycle a queued trigger is consumed first; a simultaneous
    // disparo then takes its place, so nothing is dropped there.
    if (start) begin
      if (hayPend && !disparo) pendNxt = pendientes - 1'b1;
    end else if (disparo) begin
      if (pendientes == PEND_MAX) ovfNxt = 1'b1;
      else                        pendNxt = pendientes + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      salida     <= 1'b0;
      ocupado    <= 1'b0;
      pendientes <= '0;
      desborde   <= 1'b0;
    end else begin
      state      <= stateNxt;
      cnt        <= cntNxt;
      salida     <= (stateNxt == HIGH);
      ocupado    <= (stateNxt != IDLE);
      pendientes <= pendNxt;
      desborde   <= ovfNxt;
    end
  end
endmodule

// File: tb/tb_generador_pulso_sostenido.sv
// Bench for generador_pulso_sostenido: three parameterisations driven with the
// same directed scenarios, checked every cycle against a countdown model.
module tb_generador_pulso_sostenido;
  logic clk = 1'b0;
  logic reset, disparo;
  logic       salA, ocuA, desA;
  logic [2:0] penA;
  logic       salB, ocuB, desB;
  logic [2:0] penB;
  logic       salC, ocuC, desC;
  logic [0:0] penC;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  generador_pulso_sostenido dutA (
    .clk(clk), .reset(reset), .disparo(disparo),
    .salida(salA), .ocupado(ocuA), .pendientes(penA), .desborde(desA));

  generador_pulso_sostenido #(.HIGH_CYCLES(1), .LOW_CYCLES(1)) dutB (
    .clk(clk), .reset(reset), .disparo(disparo),
    .salida(salB), .ocupado(ocuB), .pendientes(penB), .desborde(desB));

  generador_pulso_sostenido #(.PEND_W(1)) dutC (
    .clk(clk), .reset(reset), .disparo(disparo),
    .salida(salC), .ocupado(ocuC), .pendientes(penC), .desborde(desC));

  // Model: remaining high / low cycles, queued count, overflow flag per instance.
  int mH[3]   = '{4, 1, 4};
  int mL[3]   = '{4, 1, 4};
  int mMax[3] = '{7, 7, 1};
  int hiLeft[3], loLeft[3], pend[3], ovf[3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      hiLeft[i] = 0; loLeft[i] = 0; pend[i] = 0; ovf[i] = 0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        hiLeft[i] = 0; loLeft[i] = 0; pend[i] = 0; ovf[i] = 0;
      end else begin
        bit canStart, st;
        canStart = (hiLeft[i] == 0) && (loLeft[i] <= 1);
        st = canStart && (disparo || pend[i] > 0);
        ovf[i] = 0;
        if (st) begin
          if (pend[i] > 0) pend[i] = pend[i] - 1 + (disparo ? 1 : 0);
          hiLeft[i] = mH[i];
          loLeft[i] = 0;
        end else begin
          if (disparo) begin
            if (pend[i] < mMax[i]) pend[i]++;
            else ovf[i] = 1;
          end
          if (hiLeft[i] > 0) begin
            hiLeft[i]--;
            if (hiLeft[i] == 0) loLeft[i] = mL[i];
          end else if (loLeft[i] > 0) begin
            loLeft[i]--;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chkX(input string name, input logic [2:0] act, input int exp);
    checks++;
    if ($isunknown(act) || int'(act) != exp) begin
      failures++;
      $display("FAIL %s: got %b expected %0d", name, act, exp);
    end
  endtask

  function automatic bit trig(input int s, input int c);
    case (s)
      1: return c == 10;
      2: return c == 10 || c == 12;
      3: return c >= 10 && c <= 21;
      4: return c >= 10 && c <= 12;
      5: return c == 10 || c == 11;
      6: return c >= 10 && c <= 12;
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    int risesA, risesC;
    bit prevA, prevC;
    reset = 1'b1;
    disparo = 1'b0;
    for (int s = 1; s <= 6; s++) begin
      risesA = 0; risesC = 0; prevA = 1'b0; prevC = 1'b0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if (c >= 1) begin
          chkX("salA", {2'b0, salA}, hiLeft[0] > 0 ? 1 : 0);
          chkX("ocuA", {2'b0, ocuA}, (hiLeft[0] + loLeft[0]) > 0 ? 1 : 0);
          chkX("penA", penA, pend[0]);
          chkX("desA", {2'b0, desA}, ovf[0]);
          chkX("salB", {2'b0, salB}, hiLeft[1] > 0 ? 1 : 0);
          chkX("ocuB", {2'b0, ocuB}, (hiLeft[1] + loLeft[1]) > 0 ? 1 : 0);
          chkX("penB", penB, pend[1]);
          chkX("desB", {2'b0, desB}, ovf[1]);
          chkX("salC", {2'b0, salC}, hiLeft[2] > 0 ? 1 : 0);
          chkX("ocuC", {2'b0, ocuC}, (hiLeft[2] + loLeft[2]) > 0 ? 1 : 0);
          chkX("penC", {2'b0, penC}, pend[2]);
          chkX("desC", {2'b0, desC}, ovf[2]);
          if (salA === 1'b1 && !prevA) risesA++;
          if (salC === 1'b1 && !prevC) risesC++;
          prevA = (salA === 1'b1);
          prevC = (salC === 1'b1);
        end

        // Literal expectations pinning the model to the documented waveforms.
        if (c == 1) chk("reset_ocuA", int'(ocuA), 0);
        if (s == 1) begin
          if (c == 11) chk("s1_sal11", int'(salA), 1);
          if (c == 15) chk("s1_sal15", int'(salA), 0);
          if (c == 18) chk("s1_ocu18", int'(ocuA), 1);
          if (c == 19) chk("s1_ocu19", int'(ocuA), 0);
        end
        if (s == 2) begin
          if (c == 13) chk("s2_pen13", int'(penA), 1);
          if (c == 19) chk("s2_sal19", int'(salA), 1);
          if (c == 19) chk("s2_pen19", int'(penA), 0);
          if (c == 26) chk("s2_ocu26", int'(ocuA), 1);
          if (c == 27) chk("s2_ocu27", int'(ocuA), 0);
        end
        if (s == 3) begin
          if (c == 18) chk("s3_pen18", int'(penA), 7);
          if (c == 19) chk("s3_des19", int'(desA), 0);
          if (c == 20) chk("s3_des20", int'(desA), 1);
          if (c == 22) chk("s3_des22", int'(desA), 1);
          if (c == 22) chk("s3_pen22", int'(penA), 7);
          if (c == 23) chk("s3_des23", int'(desA), 0);
          if (c == 82) chk("s3_ocu82", int'(ocuA), 1);
          if (c == 83) chk("s3_ocu83", int'(ocuA), 0);
        end
        if (s == 4 && c == 14) begin
          chk("s4_sal14", int'(salA), 0);
          chk("s4_ocu14", int'(ocuA), 0);
          chk("s4_pen14", int'(penA), 0);
        end
        if (s == 4 && c == 30) chk("s4_ocu30", int'(ocuA), 0);
        if (s == 5) begin
          if (c == 11) chk("s5_sal11", int'(salB), 1);
          if (c == 12) chk("s5_sal12", int'(salB), 0);
          if (c == 12) chk("s5_pen12", int'(penB), 1);
          if (c == 13) chk("s5_sal13", int'(salB), 1);
          if (c == 14) chk("s5_sal14", int'(salB), 0);
          if (c == 15) chk("s5_ocu15", int'(ocuB), 0);
        end
        if (s == 6) begin
          if (c == 12) chk("s6_pen12", int'(penC), 1);
          if (c == 13) chk("s6_des13", int'(desC), 1);
          if (c == 19) chk("s6_sal19", int'(salC), 1);
          if (c == 27) chk("s6_ocu27", int'(ocuC), 0);
        end

        reset   = (c <= 2) || (s == 4 && c == 13);
        disparo = trig(s, c);
      end
      if (s == 3) chk("s3_pulses", risesA, 9);
      if (s == 6) chk("s6_pulses", risesC, 2);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/generador_pulso_sostenido.md
Name: generador_pulso_sostenido

Overview:
- Takes single-cycle trigger pulses (e.g. from an edge detector or control FSM) and regenerates them as clean, held level pulses.
- Each output pulse is high for exactly HIGH_CYCLES clocks, then low for at least LOW_CYCLES clocks.
- The output is stable enough for a multi-stage flip-flop edge/debounce detector on the receiving side to recognise each pulse exactly once.
- Triggers arriving while a pulse is in progress are queued in a saturating pending counter; triggers that arrive when the counter is full are reported as overflow.

Parameters:
- HIGH_CYCLES, 4, clocks salida is held high per pulse (>=1).
- LOW_CYCLES, 4, minimum clocks salida is held low after each pulse (>=1).
- PEND_W, 3, width of pending-trigger counter; max queued = 2^PEND_W-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous reset, active-high.
- disparo  in  1  trigger; each cycle it is high counts as one request.
- salida  out  1  regenerated held pulse, registered.
- ocupado  out  1  high while in HIGH or LOW phase, registered, aligned with salida.
- pendientes  out  PEND_W  queued triggers not yet emitted, registered.
- desborde  out  1  one-cycle pulse: a trigger was dropped because pendientes was full.

Behaviour:
- Reset: one clock edge with reset=1 sets state=IDLE, salida=0, ocupado=0, pendientes=0, desborde=0 and the phase counter to 0.
  - disparo is ignored while reset=1.
  - Reset mid-pulse forces salida=0 at the next edge and discards all pending triggers.
- States:
  - IDLE: salida=0, ocupado=0.
  - HIGH: salida=1, ocupado=1.
  - LOW: salida=0, ocupado=1.
- Phase counter width is clog2(max(HIGH_CYCLES, LOW_CYCLES)+1). It counts cycles spent in the current phase.
- Start condition is evaluated in IDLE and on the last LOW cycle: start = disparo | (pendientes != 0).
- IDLE with start -> HIGH at next edge; latency is 1 clock from disparo to salida=1.
- HIGH -> LOW after exactly HIGH_CYCLES cycles in HIGH.
- LOW, last cycle (LOW_CYCLES-th):
  - start -> HIGH directly, with no IDLE bubble.
  - otherwise -> IDLE.
- Pending counter update, by case:
  - Start cycle, pendientes=0, disparo=1: trigger consumed directly; pendientes unchanged.
  - Start cycle, pendientes>0: decrement by 1; if disparo=1 also, increment by 1 (net unchanged, never dropped).
  - Non-start cycle, disparo=1, pendientes < max: increment.
  - Non-start cycle, disparo=1, pendientes = max: trigger dropped; pendientes stays at max; desborde=1 at the next edge for 1 cycle.
- desborde is 0 in every other cycle; it is not sticky.
- No other output changes without a clock edge; all outputs come from flip-flops.

Test Plan:
1. Defaults; reset cycles 0-2; disparo=1 at cycle 10 only.
   -> salida=1 cycles 11-14, 0 from 15; ocupado=1 cycles 11-18, 0 at 19; pendientes=0 throughout; desborde never 1.
2. Defaults; disparo at cycles 10 and 12.
   -> first pulse high 11-14; pendientes=1 cycles 13-18, 0 at 19; second pulse high 19-22, low 23-26; ocupado continuous 11-26.
3. Defaults; disparo held high cycles 10-21.
   -> pendientes climbs 1..7 over cycles 12-18 and stays 7 at cycles 18-19 (cycle 18 start is net zero).
   -> triggers at 19, 20, 21 dropped; desborde=1 cycles 20-22; pendientes=7 at 22.
   -> afterwards 7 further back-to-back pulses, each high 4 / low 4, then IDLE.
4. Defaults; disparo at 10, 11, 12; reset=1 at cycle 13.
   -> at cycle 14: salida=0, ocupado=0, pendientes=0, desborde=0; no further pulses with disparo=0.
5. HIGH_CYCLES=1, LOW_CYCLES=1; disparo at cycles 10 and 11.
   -> salida 1,0,1,0 on cycles 11,12,13,14; pendientes=1 at cycle 12 only; IDLE from cycle 15.
6. PEND_W=1; disparo at cycles 10, 11, 12.
   -> pendientes=1 from cycle 12; trigger at 12 dropped; desborde=1 at cycle 13; exactly 2 output pulses emitted (high 11-14 and 19-22).
